assoc_cache: RTL and testbench
==============================

ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameter ARCH_BITS, default 32: address and data word width.
REQ-002 Parameter LINE_BITS, default 128: cache line width, equal to the memory line width.
REQ-003 Parameter SETS, default 4: number of sets; power of two, at least 2.
REQ-004 Parameter WAYS, default 2: associativity; one of 1, 2 or 4.
REQ-005 Port clk, in, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst, in, 1: reset, asynchronous, active-low.
REQ-007 Port reqValid, in, 1: a CPU request is present.
REQ-008 Port reqWrite, in, 1: 1 = store, 0 = load.
REQ-009 Port reqByte, in, 1: store writes the low byte only; loads always return a full word.
REQ-010 Port reqAddr, in, ARCH_BITS: request address; word-aligned unless reqByte.
REQ-011 Port reqWData, in, ARCH_BITS: store data.
REQ-012 Port reqReady, out, 1: the request is accepted this cycle.
REQ-013 Port respValid, out, 1: one-cycle pulse; the request completed.
REQ-014 Port respData, out, ARCH_BITS: load word, valid only with respValid.
REQ-015 Port memRdReq / memRdAddr, out, 1 / ARCH_BITS: refill request and line-aligned address.
REQ-016 Port memRdData / memRdValid, in, LINE_BITS / 1: refill line and its one-cycle valid strobe.
REQ-017 Port memWrReq / memWrAddr / memWrLine, out, 1 / ARCH_BITS / LINE_BITS: write-back request, line-aligned address and line data.
REQ-018 Port memWrAck, in, 1: write-back accepted.
REQ-019 Port flush / flushDone, in / out, 1 / 1: flush request and its one-cycle completion pulse.

Function
REQ-020 Address split: tag | set index (log2 SETS bits) | word offset (log2(LINE_BITS/ARCH_BITS) bits) | byte offset (log2(ARCH_BITS/8) bits).
REQ-021 FSM states: IDLE, LOOKUP, WRBACK, REFILL, FLUSH.
REQ-022 reqReady is high only in IDLE with flush low; an accepted request is registered and the FSM moves to LOOKUP.
REQ-023 LOOKUP hit (valid and tag equal in any way): respValid in that cycle, which is 1-cycle latency after acceptance; the FSM returns to IDLE.
REQ-024 A store hit updates the word (or, with reqByte, only the selected byte) and sets the dirty bit on the same edge.
REQ-025 Victim selection on a miss: the lowest-index invalid way; if all ways are valid, the least-recently-used way.
REQ-026 LRU: each way holds a log2(WAYS)-bit age per set; an access sets the touched way to 0 and increments the ages lower than its previous age; refill counts as an access.
REQ-027 Miss with a dirty victim: go to WRBACK; hold memWrReq with a stable address and line until memWrAck is sampled; then go to REFILL.
REQ-028 Miss with a clean victim: go directly to REFILL.
REQ-029 REFILL: hold memRdReq until memRdValid; then install the line (valid=1, dirty=0, new tag) and return to LOOKUP, which now hits and completes the request.
REQ-030 memRdReq and memWrReq are never high in the same cycle.
REQ-031 memRdValid or memWrAck arriving outside REFILL or WRBACK respectively is ignored.
REQ-032 flush in IDLE enters FLUSH.
REQ-033 FLUSH visits every set and way in ascending order, writes back each dirty line with the WRBACK handshake, and clears all valid and dirty bits.
REQ-034 FLUSH ends with a flushDone pulse and a return to IDLE; flush takes priority over reqValid in IDLE.

Reset
REQ-035 On rst low, immediately: FSM=IDLE; all valid, dirty and age bits =0; reqReady=0 while rst is low; respValid, memRdReq, memWrReq, flushDone =0; respData=0.
REQ-036 Line data and tag arrays are not reset.
REQ-037 Reset asserted mid-WRBACK or mid-REFILL abandons the transaction; no line is installed.

Structure
REQ-038 The FSM state encoding and the address-field width functions live in the shared proc package, alongside ARCH_BITS, BYTE_BITS and MEMORY_LINE_BITS.
REQ-039 One sub-module, cache_lru, holds the per-set ages and exposes victim-way and touch ports.

Verification
REQ-040 Load 0x40 from reset, memRdData=0x44444444_33333333_22222222_11111111 -> memRdReq with memRdAddr=0x40, then respData=0x11111111; a repeat load of 0x44 -> respValid one cycle after accept, respData=0x22222222.
REQ-041 WAYS=2: loads to 0x000, 0x040, 0x000, then 0x080 (same set) -> 0x080 evicts the 0x040 way; a reload of 0x000 hits.
REQ-042 Store 0xDEADBEEF to 0x000, then load of a conflicting 0x040 and 0x080 -> memWrReq, memWrAddr=0x000, with word0 of memWrLine =0xDEADBEEF; memRdReq stays low until memWrAck.
REQ-043 Byte store 0xAB to 0x003 over 0x11111111 -> a subsequent load returns the byte-3-updated word, other bytes unchanged.
REQ-044 Two dirty lines, then flush -> exactly two write-backs in set/way order, then flushDone=1 for one cycle, then all loads miss.
REQ-045 rst low while memRdReq=1 -> memRdReq=0 immediately; after release, a load of the same address misses again.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor package: core widths, cache FSM states
// and address-field width helpers.
package proc_pkg;

  localparam int ARCH_BITS        = 32;
  localparam int BYTE_BITS        = 8;
  localparam int MEMORY_LINE_BITS = 128;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRBACK,
    REFILL,
    FLUSH
  } cacheState_t;

  function automatic int setBits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int byteBits(input int arch);
    return $clog2(arch / BYTE_BITS);
  endfunction

  function automatic int offBits(input int line, input int arch);
    return $clog2(line / arch) + byteBits(arch);
  endfunction

  function automatic int tagBits(
    input int arch,
    input int line,
    input int sets
  );
    return arch - setBits(sets) - offBits(line, arch);
  endfunction

  function automatic int wayBits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set LRU ages for the associative cache.
// Ports: rdSet -> victimWay (oldest way), touch/touchSet/touchWay update.
module cache_lru #(
  parameter int SETS = 4,
  parameter int WAYS = 2,
  parameter int SB   = 2,
  parameter int AW   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SB-1:0] rdSet,
  output logic [AW-1:0] victimWay,
  input  logic          touch,
  input  logic [SB-1:0] touchSet,
  input  logic [AW-1:0] touchWay
);

  logic [AW-1:0] age [SETS][WAYS];
  logic [AW-1:0] best;
  logic [AW-1:0] prev;

  always_comb begin
    best      = age[rdSet][0];
    victimWay = '0;
    for (int w = 1; w < WAYS; w++) begin
      if (age[rdSet][w] > best) begin
        best      = age[rdSet][w];
        victimWay = AW'(w);
      end
    end
  end

  assign prev = age[touchSet][touchWay];

  // Equal ages are aged too, so the all-zero reset state
  // settles into distinct ages as the ways fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= '0;
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == touchWay)
          age[touchSet][w] <= '0;
        else if (age[touchSet][w] <= prev &&
                 age[touchSet][w] != AW'(WAYS - 1))
          age[touchSet][w] <= age[touchSet][w] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// Set-associative write-back cache with LRU replacement and flush.
// Ports: CPU req/resp, line refill (memRd*), write-back (memWr*), flush.
module assoc_cache #(
  parameter int ARCH_BITS = 32,
  parameter int LINE_BITS = 128,
  parameter int SETS      = 4,
  parameter int WAYS      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reqValid,
  input  logic                 reqWrite,
  input  logic                 reqByte,
  input  logic [ARCH_BITS-1:0] reqAddr,
  input  logic [ARCH_BITS-1:0] reqWData,
  output logic                 reqReady,
  output logic                 respValid,
  output logic [ARCH_BITS-1:0] respData,
  output logic                 memRdReq,
  output logic [ARCH_BITS-1:0] memRdAddr,
  input  logic [LINE_BITS-1:0] memRdData,
  input  logic                 memRdValid,
  output logic                 memWrReq,
  output logic [ARCH_BITS-1:0] memWrAddr,
  output logic [LINE_BITS-1:0] memWrLine,
  input  logic                 memWrAck,
  input  logic                 flush,
  output logic                 flushDone
);
  import proc_pkg::*;

  localparam int SB = setBits(SETS);
  localparam int BB = byteBits(ARCH_BITS);
  localparam int OB = offBits(LINE_BITS, ARCH_BITS);
  localparam int WB = OB - BB;
  localparam int TB = tagBits(ARCH_BITS, LINE_BITS, SETS);
  localparam int AW = wayBits(WAYS);

  cacheState_t state, nxt;

  logic [ARCH_BITS-1:0] rAddr, rWData;
  logic                 rWrite, rByte;

  logic [LINE_BITS-1:0] dataArr [SETS][WAYS];
  logic [TB-1:0]        tagArr  [SETS][WAYS];
  logic [WAYS-1:0]      valid   [SETS];
  logic [WAYS-1:0]      dirty   [SETS];

  logic [AW-1:0] vWay, wbWay, fWay;
  logic [AW-1:0] hitWay, invWay, victim, lruWay, touchWay;
  logic [SB-1:0] wbSet, fSet;
  logic          flushing, hit, hasInv, fLast, touch;

  logic [LINE_BITS-1:0] hitLine, newLine;
  logic [ARCH_BITS-1:0] hitWord;

  logic [TB-1:0] tag;
  logic [SB-1:0] idx;
  logic [WB-1:0] wSel;
  logic [BB-1:0] bSel;

  assign tag  = rAddr[ARCH_BITS-1 -: TB];
  assign idx  = rAddr[OB +: SB];
  assign wSel = rAddr[BB +: WB];
  assign bSel = rAddr[BB-1:0];

  always_comb begin
    hit    = 1'b0;
    hitWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[idx][w] && tagArr[idx][w] == tag) begin
        hit    = 1'b1;
        hitWay = AW'(w);
      end
    end
  end

  always_comb begin
    hasInv = 1'b0;
    invWay = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[idx][w]) begin
        hasInv = 1'b1;
        invWay = AW'(w);
      end
    end
    victim = hasInv ? invWay : lruWay;
  end

  always_comb begin
    hitLine = dataArr[idx][hitWay];
    hitWord = hitLine[int'(wSel)*ARCH_BITS +: ARCH_BITS];
    newLine = hitLine;
    if (rByte)
      newLine[int'(wSel)*ARCH_BITS + int'(bSel)*8 +: 8] = rWData[7:0];
    else
      newLine[int'(wSel)*ARCH_BITS +: ARCH_BITS] = rWData;
  end

  assign fLast = (fSet == SB'(SETS - 1)) &&
                 (fWay == AW'(WAYS - 1));

  assign touch = (state == LOOKUP && hit) ||
                 (state == REFILL && memRdValid);
  assign touchWay = (state == REFILL) ? vWay : hitWay;

  cache_lru #(
    .SETS(SETS),
    .WAYS(WAYS),
    .SB  (SB),
    .AW  (AW)
  ) uLru (
    .clk      (clk),
    .rst      (rst),
    .rdSet    (idx),
    .victimWay(lruWay),
    .touch    (touch),
    .touchSet (idx),
    .touchWay (touchWay)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (flush)         nxt = FLUSH;
        else if (reqValid) nxt = LOOKUP;
      LOOKUP:
        if (hit)                    nxt = IDLE;
        else if (dirty[idx][victim]) nxt = WRBACK;
        else                        nxt = REFILL;
      WRBACK:
        if (memWrAck) nxt = flushing ? FLUSH : REFILL;
      REFILL:
        if (memRdValid) nxt = LOOKUP;
      FLUSH:
        if (dirty[fSet][fWay]) nxt = WRBACK;
        else if (fLast)        nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rAddr    <= '0;
      rWData   <= '0;
      rWrite   <= 1'b0;
      rByte    <= 1'b0;
      vWay     <= '0;
      wbWay    <= '0;
      wbSet    <= '0;
      fWay     <= '0;
      fSet     <= '0;
      flushing <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
    end else begin
      state <= nxt;
      unique case (state)
        IDLE:
          if (flush) begin
            fSet <= '0;
            fWay <= '0;
          end else if (reqValid) begin
            rAddr  <= reqAddr;
            rWData <= reqWData;
            rWrite <= reqWrite;
            rByte  <= reqByte;
          end
        LOOKUP:
          if (hit) begin
            if (rWrite) dirty[idx][hitWay] <= 1'b1;
          end else begin
            vWay     <= victim;
            wbSet    <= idx;
            wbWay    <= victim;
            flushing <= 1'b0;
          end
        WRBACK:
          if (memWrAck && flushing)
            dirty[wbSet][wbWay] <= 1'b0;
        REFILL:
          if (memRdValid) begin
            valid[idx][vWay] <= 1'b1;
            dirty[idx][vWay] <= 1'b0;
          end
        FLUSH:
          if (dirty[fSet][fWay]) begin
            wbSet    <= fSet;
            wbWay    <= fWay;
            flushing <= 1'b1;
          end else begin
            valid[fSet][fWay] <= 1'b0;
            if (!fLast) begin
              if (fWay == AW'(WAYS - 1)) begin
                fWay <= '0;
                fSet <= fSet + 1'b1;
              end else begin
                fWay <= fWay + 1'b1;
              end
            end
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && rWrite)
      dataArr[idx][hitWay] <= newLine;
    if (state == REFILL && memRdValid) begin
      dataArr[idx][vWay] <= memRdData;
      tagArr[idx][vWay]  <= tag;
    end
  end

  assign reqReady  = rst && state == IDLE && !flush;
  assign respValid = state == LOOKUP && hit;
  assign respData  = (respValid && !rWrite) ? hitWord : '0;
  assign memRdReq  = state == REFILL;
  assign memRdAddr = {tag, idx, {OB{1'b0}}};
  assign memWrReq  = state == WRBACK;
  assign memWrAddr = {tagArr[wbSet][wbWay], wbSet, {OB{1'b0}}};
  assign memWrLine = dataArr[wbSet][wbWay];
  assign flushDone = state == FLUSH && fLast &&
                     !dirty[fSet][fWay];

endmodule

// File: tb/tb_assoc_cache.sv
// Directed testbench for assoc_cache with a small line-memory model.
// Each scenario task checks its own hand-computed expectations.
module tb_assoc_cache;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         reqValid = 1'b0;
  logic         reqWrite = 1'b0;
  logic         reqByte = 1'b0;
  logic [31:0]  reqAddr = '0;
  logic [31:0]  reqWData = '0;
  logic         reqReady;
  logic         respValid;
  logic [31:0]  respData;
  logic         memRdReq;
  logic [31:0]  memRdAddr;
  logic [127:0] memRdData = '0;
  logic         memRdValid = 1'b0;
  logic         memWrReq;
  logic [31:0]  memWrAddr;
  logic [127:0] memWrLine;
  logic         memWrAck = 1'b0;
  logic         flush = 1'b0;
  logic         flushDone;

  int compared = 0;
  int mismatched = 0;

  localparam logic [127:0] MAGIC =
    128'h44444444_33333333_22222222_11111111;

  logic [127:0] lineMem [64];
  int           rdCount = 0;
  int           wbCount = 0;
  logic [31:0]  lastRdAddr = '0;
  logic [31:0]  wbAddrQ [$];
  logic [31:0]  wbWord0Q [$];
  bit           memEn = 1'b1;
  bit           rdDuringWb = 1'b0;
  bit           overlap = 1'b0;
  bit           wbOpen = 1'b0;
  int           rdWait = 0;
  int           wrWait = 0;

  assoc_cache dut (
    .clk       (clk),
    .rst       (rst),
    .reqValid  (reqValid),
    .reqWrite  (reqWrite),
    .reqByte   (reqByte),
    .reqAddr   (reqAddr),
    .reqWData  (reqWData),
    .reqReady  (reqReady),
    .respValid (respValid),
    .respData  (respData),
    .memRdReq  (memRdReq),
    .memRdAddr (memRdAddr),
    .memRdData (memRdData),
    .memRdValid(memRdValid),
    .memWrReq  (memWrReq),
    .memWrAddr (memWrAddr),
    .memWrLine (memWrLine),
    .memWrAck  (memWrAck),
    .flush     (flush),
    .flushDone (flushDone)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] defLine(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {16'hA000, b, 8'd3, 16'hA000, b, 8'd2,
            16'hA000, b, 8'd1, 16'hA000, b, 8'd0};
  endfunction

  task automatic initMem();
    for (int i = 0; i < 64; i++) lineMem[i] = defLine(i);
    lineMem[0] = MAGIC;
    lineMem[4] = MAGIC;
  endtask

  // Memory model: refill after 2 cycles, write-back ack after 3.
  initial begin
    forever begin
      @(negedge clk);
      memRdValid = 1'b0;
      memWrAck = 1'b0;
      if (memRdReq && memWrReq) overlap = 1'b1;
      if (memRdReq && wbOpen) rdDuringWb = 1'b1;
      if (memWrReq) wbOpen = 1'b1;
      if (!memRdReq) rdWait = 0;
      if (!memWrReq) wrWait = 0;
      if (memEn && memRdReq) begin
        rdWait++;
        if (rdWait == 2) begin
          memRdData = lineMem[memRdAddr[9:4]];
          memRdValid = 1'b1;
          lastRdAddr = memRdAddr;
          rdCount++;
          rdWait = 0;
        end
      end
      if (memEn && memWrReq) begin
        wrWait++;
        if (wrWait == 3) begin
          lineMem[memWrAddr[9:4]] = memWrLine;
          wbAddrQ.push_back(memWrAddr);
          wbWord0Q.push_back(memWrLine[31:0]);
          wbCount++;
          memWrAck = 1'b1;
          wbOpen = 1'b0;
          wrWait = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    reqValid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wbOpen = 1'b0;
  endtask

  task automatic doReq(
    input  logic        w,
    input  logic        b,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output logic [31:0] rd,
    output int          lat
  );
    int n;
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = w;
    reqByte = b;
    reqAddr = a;
    reqWData = d;
    n = 0;
    while (!reqReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (reqReady !== 1'b1) begin
      $display("FAIL accept_timeout addr=%h got %b need 1", a, reqReady);
      mismatched++;
    end
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    lat = 1;
    while (!respValid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    rd = respData;
    compared++;
    if (respValid !== 1'b1) begin
      $display("FAIL resp_timeout addr=%h got %b need 1", a, respValid);
      mismatched++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reqValid = 1'b1;
    #1;
    compared++;
    if (reqReady !== 1'b0) begin
      $display("FAIL rst_reqReady got %b need 0", reqReady);
      mismatched++;
    end
    compared++;
    if (respValid !== 1'b0) begin
      $display("FAIL rst_respValid got %b need 0", respValid);
      mismatched++;
    end
    compared++;
    if (memRdReq !== 1'b0 || memWrReq !== 1'b0) begin
      $display("FAIL rst_memReq got rd=%b wr=%b need 0 0",
               memRdReq, memWrReq);
      mismatched++;
    end
    compared++;
    if (flushDone !== 1'b0) begin
      $display("FAIL rst_flushDone got %b need 0", flushDone);
      mismatched++;
    end
    compared++;
    if (respData !== 32'h0) begin
      $display("FAIL rst_respData got %h need 0", respData);
      mismatched++;
    end
    reqValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if (reqReady !== 1'b1) begin
      $display("FAIL idle_reqReady got %b need 1", reqReady);
      mismatched++;
    end
  endtask

  task automatic test_refill_load();
    logic [31:0] d;
    int lat, c0;
    initMem();
    doReset();
    c0 = rdCount;
    doReq(1'b0, 1'b0, 32'h40, 32'h0, d, lat);
    compared++;
    if (rdCount - c0 !== 1) begin
      $display("FAIL refill_count got %0d need 1", rdCount - c0);
      mismatched++;
    end
    compared++;
    if (lastRdAddr !== 32'h40) begin
      $display("FAIL refill_addr got %h need 00000040", lastRdAddr);
      mismatched++;
    end
    compared++;
    if (d !== 32'h11111111) begin
      $display("FAIL refill_data got %h need 11111111", d);
      mismatched++;
    end
    doReq(1'b0, 1'b0, 32'h44, 32'h0, d, lat);
    compared++;
    if (lat !== 1) begin
      $display("FAIL hit_latency got %0d need 1", lat);
      mismatched++;
    end
    compared++;
    if (d !== 32'h22222222) begin
      $display("FAIL hit_data got %h need 22222222", d);
      mismatched++;
    end
    compared++;
    if (rdCount - c0 !== 1) begin
      $display("FAIL hit_no_refill got %0d need 1", rdCount - c0);
      mismatched++;
    end
  endtask

  task automatic test_lru_evict();
    logic [31:0] d;
    int lat, c0;
    initMem();
    doReset();
    doReq(1'b0, 1'b0, 32'h000, 32'h0, d, lat);
    doReq(1'b0, 1'b0, 32'h040, 32'h0, d, lat);
    doReq(1'b0, 1'b0, 32'h000, 32'h0, d, lat);
    compared++;
    if (lat !== 1) begin
      $display("FAIL lru_rehit_lat got %0d need 1", lat);
      mismatched++;
    end
    c0 = rdCount;
    doReq(1'b0, 1'b0, 32'h080, 32'h0, d, lat);
    compared++;
    if (d !== 32'hA0000800 || rdCount - c0 !== 1) begin
      $display("FAIL lru_080 got %h/%0d need a0000800/1",
               d, rdCount - c0);
      mismatched++;
    end
    doReq(1'b0, 1'b0, 32'h000, 32'h0, d, lat);
    compared++;
    if (lat !== 1 || d !== 32'h11111111) begin
      $display("FAIL lru_keep_000 got lat=%0d %h need 1 11111111",
               lat, d);
      mismatched++;
    end
    c0 = rdCount;
    doReq(1'b0, 1'b0, 32'h040, 32'h0, d, lat);
    compared++;
    if (rdCount - c0 !== 1) begin
      $display("FAIL lru_040_evicted got %0d need 1", rdCount - c0);
      mismatched++;
    end
  endtask

  task automatic test_writeback();
    logic [31:0] d;
    int lat, w0, c0;
    initMem();
    doReset();
    wbAddrQ.delete();
    wbWord0Q.delete();
    doReq(1'b1, 1'b0, 32'h000, 32'hDEADBEEF, d, lat);
    doReq(1'b0, 1'b0, 32'h040, 32'h0, d, lat);
    w0 = wbCount;
    rdDuringWb = 1'b0;
    overlap = 1'b0;
    doReq(1'b0, 1'b0, 32'h080, 32'h0, d, lat);
    compared++;
    if (wbCount - w0 !== 1) begin
      $display("FAIL wb_count got %0d need 1", wbCount - w0);
      mismatched++;
    end
    compared++;
    if (wbAddrQ.size() != 1 || wbAddrQ[0] !== 32'h0) begin
      $display("FAIL wb_addr got %h need 00000000", wbAddrQ[0]);
      mismatched++;
    end
    compared++;
    if (wbWord0Q[0] !== 32'hDEADBEEF) begin
      $display("FAIL wb_word0 got %h need deadbeef", wbWord0Q[0]);
      mismatched++;
    end
    compared++;
    if (rdDuringWb !== 1'b0 || overlap !== 1'b0) begin
      $display("FAIL wb_rd_order got rdEarly=%b overlap=%b need 0 0",
               rdDuringWb, overlap);
      mismatched++;
    end
    compared++;
    if (d !== 32'hA0000800) begin
      $display("FAIL wb_load_080 got %h need a0000800", d);
      mismatched++;
    end
    c0 = rdCount;
    doReq(1'b0, 1'b0, 32'h000, 32'h0, d, lat);
    compared++;
    if (d !== 32'hDEADBEEF || rdCount - c0 !== 1) begin
      $display("FAIL wb_reload got %h/%0d need deadbeef/1",
               d, rdCount - c0);
      mismatched++;
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] d;
    int lat;
    initMem();
    doReset();
    doReq(1'b0, 1'b0, 32'h000, 32'h0, d, lat);
    compared++;
    if (d !== 32'h11111111) begin
      $display("FAIL byte_pre got %h need 11111111", d);
      mismatched++;
    end
    doReq(1'b1, 1'b1, 32'h003, 32'h000000AB, d, lat);
    compared++;
    if (lat !== 1) begin
      $display("FAIL byte_store_lat got %0d need 1", lat);
      mismatched++;
    end
    doReq(1'b0, 1'b0, 32'h000, 32'h0, d, lat);
    compared++;
    if (d !== 32'hAB111111) begin
      $display("FAIL byte_word got %h need ab111111", d);
      mismatched++;
    end
    doReq(1'b0, 1'b0, 32'h004, 32'h0, d, lat);
    compared++;
    if (d !== 32'h22222222) begin
      $display("FAIL byte_neighbour got %h need 22222222", d);
      mismatched++;
    end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int lat, w0, c0, n;
    initMem();
    doReset();
    wbAddrQ.delete();
    wbWord0Q.delete();
    doReq(1'b1, 1'b0, 32'h000, 32'h55550000, d, lat);
    doReq(1'b1, 1'b0, 32'h010, 32'h66660000, d, lat);
    doReq(1'b0, 1'b0, 32'h040, 32'h0, d, lat);
    w0 = wbCount;
    @(negedge clk);
    flush = 1'b1;
    reqValid = 1'b1;
    reqAddr = 32'h000;
    #1;
    compared++;
    if (reqReady !== 1'b0) begin
      $display("FAIL flush_priority got %b need 0", reqReady);
      mismatched++;
    end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    reqValid = 1'b0;
    n = 0;
    while (!flushDone && n < 300) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (flushDone !== 1'b1) begin
      $display("FAIL flush_done got %b need 1", flushDone);
      mismatched++;
    end
    compared++;
    if (wbCount - w0 !== 2) begin
      $display("FAIL flush_wb_count got %0d need 2", wbCount - w0);
      mismatched++;
    end
    compared++;
    if (wbAddrQ.size() != 2 || wbAddrQ[0] !== 32'h000 ||
        wbAddrQ[1] !== 32'h010) begin
      $display("FAIL flush_wb_order got %h %h need 00000000 00000010",
               wbAddrQ[0], wbAddrQ[1]);
      mismatched++;
    end
    @(negedge clk);
    compared++;
    if (flushDone !== 1'b0) begin
      $display("FAIL flush_pulse got %b need 0", flushDone);
      mismatched++;
    end
    c0 = rdCount;
    doReq(1'b0, 1'b0, 32'h000, 32'h0, d, lat);
    compared++;
    if (d !== 32'h55550000) begin
      $display("FAIL flush_reload got %h need 55550000", d);
      mismatched++;
    end
    doReq(1'b0, 1'b0, 32'h040, 32'h0, d, lat);
    compared++;
    if (rdCount - c0 !== 2) begin
      $display("FAIL flush_all_miss got %0d need 2", rdCount - c0);
      mismatched++;
    end
  endtask

  task automatic test_reset_refill();
    logic [31:0] d;
    int lat, c0, n;
    initMem();
    doReset();
    memEn = 1'b0;
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = 1'b0;
    reqByte = 1'b0;
    reqAddr = 32'h0C0;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    n = 0;
    while (!memRdReq && n < 20) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (memRdReq !== 1'b1) begin
      $display("FAIL rr_rdreq got %b need 1", memRdReq);
      mismatched++;
    end
    #2;
    rst = 1'b0;
    #1;
    compared++;
    if (memRdReq !== 1'b0 || reqReady !== 1'b0) begin
      $display("FAIL rr_async got rd=%b ready=%b need 0 0",
               memRdReq, reqReady);
      mismatched++;
    end
    @(negedge clk);
    rst = 1'b1;
    memEn = 1'b1;
    c0 = rdCount;
    doReq(1'b0, 1'b0, 32'h0C0, 32'h0, d, lat);
    compared++;
    if (rdCount - c0 !== 1 || d !== 32'hA0000C00) begin
      $display("FAIL rr_miss_again got %0d/%h need 1/a0000c00",
               rdCount - c0, d);
      mismatched++;
    end
  endtask

  initial begin
    initMem();
    test_reset();
    test_refill_load();
    test_lru_evict();
    test_writeback();
    test_byte_store();
    test_flush();
    test_reset_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
